// File: rtl/wts_channel_mixer.sv
// rtl/wts_channel_mixer.sv - scales time-multiplexed channel slots by envelope and volume, sums them per frame
module wts_channel_mixer #(
    parameter int CH_NUM    = 5,
    parameter int OUT_WIDTH = 11
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 active,
    input  logic                 clear,
    input  logic                 enable,
    input  logic                 ch_valid,
    input  logic [2:0]           ch_index,
    input  logic [7:0]           ch_wave,
    input  logic [8:0]           ch_envelope,
    input  logic [3:0]           ch_volume,
    input  logic [CH_NUM-1:0]    ch_mask,
    output logic [OUT_WIDTH-1:0] sample_out,
    output logic                 out_valid
);

    // Extra headroom lets duplicated slot indices pile up without wrapping.
    localparam int ACC_MIN = 8 + $clog2(CH_NUM) + 1 + 4;
    localparam int ACC_W   = (OUT_WIDTH + 1 > ACC_MIN) ? OUT_WIDTH + 1 : ACC_MIN;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic                    v1, last1, v2, last2;
    logic signed [8:0]       p1;
    logic [3:0]              vol1;
    logic signed [7:0]       p2;
    logic signed [ACC_W-1:0] acc;

    logic                    slot_ok;
    logic                    mask_bit;
    logic signed [17:0]      prod1;
    logic signed [17:0]      shift1;
    logic signed [13:0]      prod2;
    logic signed [13:0]      shift2;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] sat_val;

    assign slot_ok = ch_valid && (32'(ch_index) < CH_NUM);

    always_comb begin
        mask_bit = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (32'(ch_index) == i) mask_bit = ch_mask[i];
        end
    end

    // Envelope is unsigned, so it gets a zero sign bit before the signed multiply.
    assign prod1  = $signed(ch_wave) * $signed({1'b0, ch_envelope});
    assign shift1 = prod1 >>> 8;
    assign prod2  = p1 * $signed({1'b0, vol1});
    assign shift2 = prod2 >>> 4;
    assign sum    = acc + ACC_W'(p2);

    always_comb begin
        sat_val = sum;
        if (sum > SAT_MAX)      sat_val = SAT_MAX;
        else if (sum < SAT_MIN) sat_val = SAT_MIN;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            v1         <= 1'b0;
            last1      <= 1'b0;
            p1         <= '0;
            vol1       <= '0;
            v2         <= 1'b0;
            last2      <= 1'b0;
            p2         <= '0;
            acc        <= '0;
            sample_out <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (active) begin
                if (clear) begin
                    v1  <= 1'b0;
                    v2  <= 1'b0;
                    acc <= '0;
                end else begin
                    v1    <= slot_ok;
                    last1 <= (32'(ch_index) == CH_NUM - 1);
                    p1    <= (slot_ok && mask_bit) ? shift1[8:0] : 9'sd0;
                    vol1  <= ch_volume;
                    v2    <= v1;
                    last2 <= last1;
                    p2    <= shift2[7:0];
                    if (v2) begin
                        if (last2) begin
                            sample_out <= enable ? sat_val[OUT_WIDTH-1:0] : '0;
                            acc        <= '0;
                            out_valid  <= 1'b1;
                        end else begin
                            acc <= sum;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wts_channel_mixer.sv
// tb/tb_wts_channel_mixer.sv - directed vector bench for wts_channel_mixer
module tb_wts_channel_mixer;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        active = 1'b0;
    logic        clear = 1'b0;
    logic        enable = 1'b1;
    logic        ch_valid = 1'b0;
    logic [2:0]  ch_index = '0;
    logic [7:0]  ch_wave = '0;
    logic [8:0]  ch_envelope = '0;
    logic [3:0]  ch_volume = '0;
    logic [4:0]  ch_mask = 5'h1F;
    logic [10:0] sample_out;
    logic        out_valid;
    logic [8:0]  sample_out9;
    logic        out_valid9;

    int checks = 0;
    int failures = 0;

    wts_channel_mixer #(.CH_NUM(5), .OUT_WIDTH(11)) dut (
        .clk(clk), .nreset(nreset), .active(active), .clear(clear), .enable(enable),
        .ch_valid(ch_valid), .ch_index(ch_index), .ch_wave(ch_wave),
        .ch_envelope(ch_envelope), .ch_volume(ch_volume), .ch_mask(ch_mask),
        .sample_out(sample_out), .out_valid(out_valid)
    );

    wts_channel_mixer #(.CH_NUM(5), .OUT_WIDTH(9)) dut9 (
        .clk(clk), .nreset(nreset), .active(active), .clear(clear), .enable(enable),
        .ch_valid(ch_valid), .ch_index(ch_index), .ch_wave(ch_wave),
        .ch_envelope(ch_envelope), .ch_volume(ch_volume), .ch_mask(ch_mask),
        .sample_out(sample_out9), .out_valid(out_valid9)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        int         wave;
        int         env;
        int         vol;
        logic [4:0] mask;
        logic       en;
        int         exp11;
        int         exp9;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic a);
        active = a;
        @(posedge clk);
        #1;
    endtask

    task automatic slot(input int idx, input int wave, input int env, input int vol);
        ch_valid    = 1'b1;
        ch_index    = 3'(idx);
        ch_wave     = 8'(wave);
        ch_envelope = 9'(env);
        ch_volume   = 4'(vol);
        step(1'b1);
        ch_valid    = 1'b0;
    endtask

    task automatic check_out(input string name, input int exp11, input int exp9);
        chk({name, " out_valid"}, int'(out_valid), 1);
        chk({name, " out_valid9"}, int'(out_valid9), 1);
        chk({name, " sample11"}, int'($signed(sample_out)), exp11);
        chk({name, " sample9"}, int'($signed(sample_out9)), exp9);
    endtask

    initial begin
        vecs[0] = '{1, 100, 256, 15, 5'h1F, 1'b1, 93, 93};
        vecs[1] = '{1, -1, 1, 15, 5'h1F, 1'b1, -1, -1};
        vecs[2] = '{1, 1, 255, 15, 5'h1F, 1'b1, 0, 0};
        vecs[3] = '{1, 100, 256, 0, 5'h1F, 1'b1, 0, 0};
        vecs[4] = '{5, -128, 256, 15, 5'h1F, 1'b1, -600, -256};
        vecs[5] = '{5, -128, 256, 15, 5'h1B, 1'b1, -480, -256};
        vecs[6] = '{5, -128, 256, 15, 5'h1F, 1'b0, 0, 0};
        vecs[7] = '{5, 127, 256, 15, 5'h1F, 1'b1, 595, 255};
        vecs[8] = '{1, -3, 100, 7, 5'h1F, 1'b1, -1, -1};
        vecs[9] = '{2, 50, 128, 8, 5'h1F, 1'b1, 24, 24};

        step(1'b1);
        step(1'b1);
        chk("reset sample", int'(sample_out), 0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset sample9", int'(sample_out9), 0);
        #2 nreset = 1'b1;

        for (int r = 0; r < 10; r++) begin
            ch_mask = vecs[r].mask;
            enable  = vecs[r].en;
            for (int s = 5 - vecs[r].n; s < 5; s++) slot(s, vecs[r].wave, vecs[r].env, vecs[r].vol);
            chk($sformatf("vec%0d early", r), int'(out_valid), 0);
            step(1'b1);
            chk($sformatf("vec%0d early2", r), int'(out_valid), 0);
            step(1'b1);
            check_out($sformatf("vec%0d", r), vecs[r].exp11, vecs[r].exp9);
            step(1'b0);
            chk($sformatf("vec%0d pulse width", r), int'(out_valid), 0);
        end
        ch_mask = 5'h1F;
        enable  = 1'b1;

        // Reset in the middle of a frame
        slot(0, 127, 256, 15);
        slot(1, 127, 256, 15);
        slot(2, 127, 256, 15);
        #2 nreset = 1'b0;
        #1;
        chk("midreset sample", int'(sample_out), 0);
        chk("midreset out_valid", int'(out_valid), 0);
        #2 nreset = 1'b1;
        slot(3, 100, 256, 15);
        slot(4, 100, 256, 15);
        step(1'b1);
        step(1'b1);
        check_out("post reset frame", 186, 186);

        // clear coincides with the closing slot reaching stage 3
        for (int s = 0; s < 5; s++) slot(s, 100, 256, 15);
        step(1'b1);
        clear = 1'b1;
        step(1'b1);
        clear = 1'b0;
        chk("clear out_valid", int'(out_valid), 0);
        chk("clear sample hold", int'($signed(sample_out)), 186);
        slot(5, 127, 256, 15);
        slot(4, -1, 1, 15);
        step(1'b1);
        step(1'b1);
        check_out("after clear", -1, -1);

        // active low stalls the pipeline
        slot(4, 100, 256, 15);
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            chk($sformatf("stall%0d out_valid", i), int'(out_valid), 0);
        end
        chk("stall sample hold", int'($signed(sample_out)), -1);
        step(1'b1);
        chk("stall resume early", int'(out_valid), 0);
        step(1'b1);
        check_out("stall resume", 93, 93);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
